// File: rtl/decode_stage_pipe.sv
// decode_stage_pipe
//   Decode stage of the 16-bit RISC pipeline, placed between fetch and execute.
//   It decodes the fetched instruction and reads operands from an internal
//   register file, with a bypass from the write-back port. It detects load-use
//   hazards and registers the result into the ID/EX pipeline register.
//
// Ports
//   clk, rst            clock; asynchronous active-low reset (0 = in reset)
//   in_valid/in_ready   fetch handshake; fetch advances on in_valid && in_ready
//   instruction         opcode[15:13] rd/rs1[12:10] rs2[9:7] imm[9:0] funct[1:0]
//   wb_reg_write/addr/data  dedicated register-file write port
//   flush               kill decoding instruction, bubble ID/EX
//   ex_stall            execute busy: hold ID/EX
//   ex_*                registered ID/EX contents
//   stall_count         saturating count of load-use bubbles
module decode_stage_pipe #(
  parameter int DATA_W = 16,
  parameter int N_REGS = 8,
  parameter int PERF_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [15:0]       instruction,
  input  logic              wb_reg_write,
  input  logic [2:0]        wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              flush,
  input  logic              ex_stall,
  output logic              ex_valid,
  output logic [1:0]        ex_alu_op,
  output logic              ex_alu_src,
  output logic              ex_wb_alu_to_reg,
  output logic              ex_reg_write,
  output logic              ex_mem_read,
  output logic              ex_mem_write,
  output logic [2:0]        ex_rd,
  output logic [DATA_W-1:0] ex_rs1_data,
  output logic [DATA_W-1:0] ex_rs2_data,
  output logic [DATA_W-1:0] ex_imm,
  output logic [PERF_W-1:0] stall_count
);

  typedef enum logic [2:0] {
    OP_NOP   = 3'b000,
    OP_ALUR  = 3'b001,
    OP_ALUI  = 3'b010,
    OP_LOAD  = 3'b011,
    OP_STORE = 3'b100
  } opcode_e;

  typedef struct packed {
    logic              valid;
    logic [1:0]        alu_op;
    logic              alu_src;
    logic              wb_alu_to_reg;
    logic              reg_write;
    logic              mem_read;
    logic              mem_write;
    logic [2:0]        rd;
    logic [DATA_W-1:0] rs1_data;
    logic [DATA_W-1:0] rs2_data;
    logic [DATA_W-1:0] imm;
  } idex_t;

  logic [2:0]        opcode;
  logic [2:0]        rs1;
  logic [2:0]        rs2;
  logic [DATA_W-1:0] regs [N_REGS];
  logic [DATA_W-1:0] rs1_val;
  logic [DATA_W-1:0] rs2_val;
  logic              use_rs1;
  logic              use_rs2;
  logic              hazard;
  idex_t             decoded;
  idex_t             idex;

  assign opcode = instruction[15:13];
  assign rs1    = instruction[12:10];
  assign rs2    = instruction[9:7];

  // Register file: R0 is an ordinary register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < N_REGS; i++) regs[i] <= '0;
    end else if (wb_reg_write) begin
      regs[wb_addr] <= wb_data;
    end
  end

  // Same-cycle write-back forwarding.
  always_comb begin
    rs1_val = regs[rs1];
    rs2_val = regs[rs2];
    if (wb_reg_write && (wb_addr == rs1)) rs1_val = wb_data;
    if (wb_reg_write && (wb_addr == rs2)) rs2_val = wb_data;
  end

  // Opcode decode; unused opcodes decode as a valid instruction with no controls.
  always_comb begin
    decoded          = '0;
    decoded.valid    = 1'b1;
    decoded.rd       = instruction[12:10];
    decoded.rs1_data = rs1_val;
    decoded.rs2_data = rs2_val;
    decoded.imm      = {{(DATA_W-10){instruction[9]}}, instruction[9:0]};
    use_rs1          = 1'b0;
    use_rs2          = 1'b0;
    case (opcode)
      OP_ALUR: begin
        decoded.alu_op        = instruction[1:0];
        decoded.reg_write     = 1'b1;
        decoded.wb_alu_to_reg = 1'b1;
        use_rs1               = 1'b1;
        use_rs2               = 1'b1;
      end
      OP_ALUI: begin
        decoded.alu_src       = 1'b1;
        decoded.reg_write     = 1'b1;
        decoded.wb_alu_to_reg = 1'b1;
        use_rs1               = 1'b1;
      end
      OP_LOAD: begin
        decoded.alu_src   = 1'b1;
        decoded.mem_read  = 1'b1;
        decoded.reg_write = 1'b1;
      end
      OP_STORE: begin
        decoded.alu_src   = 1'b1;
        decoded.mem_write = 1'b1;
        use_rs1           = 1'b1;
      end
      default: ;
    endcase
  end

  assign hazard = in_valid && idex.valid && idex.mem_read &&
                  ((use_rs1 && (idex.rd == rs1)) || (use_rs2 && (idex.rd == rs2)));

  // flush > ex_stall > hazard > normal
  assign in_ready = flush || (!ex_stall && !hazard);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idex        <= '0;
      stall_count <= '0;
    end else if (flush) begin
      idex <= '0;
    end else if (ex_stall) begin
      idex <= idex;
    end else if (hazard) begin
      idex <= '0;
      if (stall_count != '1) stall_count <= stall_count + 1'b1;
    end else if (in_valid) begin
      idex <= decoded;
    end else begin
      idex <= '0;
    end
  end

  assign ex_valid         = idex.valid;
  assign ex_alu_op        = idex.alu_op;
  assign ex_alu_src       = idex.alu_src;
  assign ex_wb_alu_to_reg = idex.wb_alu_to_reg;
  assign ex_reg_write     = idex.reg_write;
  assign ex_mem_read      = idex.mem_read;
  assign ex_mem_write     = idex.mem_write;
  assign ex_rd            = idex.rd;
  assign ex_rs1_data      = idex.rs1_data;
  assign ex_rs2_data      = idex.rs2_data;
  assign ex_imm           = idex.imm;

endmodule

// File: tb/tb_decode_stage_pipe.sv
// Bench for decode_stage_pipe: a 16-bit/16-bit-counter build and a
// 32-bit/2-bit-counter build share the same stimulus.
module tb_decode_stage_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] instruction = '0;
  logic        wb_reg_write = 1'b0;
  logic [2:0]  wb_addr = '0;
  logic [31:0] wb_data = '0;
  logic        flush = 1'b0;
  logic        ex_stall = 1'b0;

  logic        a_rdy, a_v, a_src, a_a2r, a_rw, a_mr, a_mw;
  logic [1:0]  a_op;
  logic [2:0]  a_rd;
  logic [15:0] a_r1, a_r2, a_imm, a_sc;
  logic        b_rdy, b_v, b_src, b_a2r, b_rw, b_mr, b_mw;
  logic [1:0]  b_op;
  logic [2:0]  b_rd;
  logic [31:0] b_r1, b_r2, b_imm;
  logic [1:0]  b_sc;

  always #5 clk = ~clk;

  decode_stage_pipe #(.DATA_W(16), .N_REGS(8), .PERF_W(16)) u16 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a_rdy),
    .instruction(instruction), .wb_reg_write(wb_reg_write), .wb_addr(wb_addr),
    .wb_data(wb_data[15:0]), .flush(flush), .ex_stall(ex_stall),
    .ex_valid(a_v), .ex_alu_op(a_op), .ex_alu_src(a_src), .ex_wb_alu_to_reg(a_a2r),
    .ex_reg_write(a_rw), .ex_mem_read(a_mr), .ex_mem_write(a_mw), .ex_rd(a_rd),
    .ex_rs1_data(a_r1), .ex_rs2_data(a_r2), .ex_imm(a_imm), .stall_count(a_sc));

  decode_stage_pipe #(.DATA_W(32), .N_REGS(8), .PERF_W(2)) u32 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_rdy),
    .instruction(instruction), .wb_reg_write(wb_reg_write), .wb_addr(wb_addr),
    .wb_data(wb_data), .flush(flush), .ex_stall(ex_stall),
    .ex_valid(b_v), .ex_alu_op(b_op), .ex_alu_src(b_src), .ex_wb_alu_to_reg(b_a2r),
    .ex_reg_write(b_rw), .ex_mem_read(b_mr), .ex_mem_write(b_mw), .ex_rd(b_rd),
    .ex_rs1_data(b_r1), .ex_rs2_data(b_r2), .ex_imm(b_imm), .stall_count(b_sc));

  typedef struct {
    logic        v;
    logic [1:0]  op;
    logic        src, a2r, rw, mr, mw;
    logic [2:0]  rd;
    logic [31:0] r1, r2, imm;
    int          sc;
  } exp_t;

  exp_t exp_q[$];
  logic rdy_q[$];
  int   total = 0;
  int   bad   = 0;
  int   hz    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h @%0t", name, act, want, $time);
    end
  endtask

  // ID/EX monitor: after each rising edge, and immediately after reset assertion.
  always @(posedge clk or negedge rst) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("a_ctrl", {25'd0, a_v, a_op, a_src, a_a2r, a_rw, a_mr, a_mw},
                    {25'd0, e.v, e.op, e.src, e.a2r, e.rw, e.mr, e.mw});
      chk("a_rd",  {29'd0, a_rd}, {29'd0, e.rd});
      chk("a_rs1", {16'd0, a_r1}, {16'd0, e.r1[15:0]});
      chk("a_rs2", {16'd0, a_r2}, {16'd0, e.r2[15:0]});
      chk("a_imm", {16'd0, a_imm}, {16'd0, e.imm[15:0]});
      chk("a_stall_count", {16'd0, a_sc}, 32'(e.sc));
      chk("b_ctrl", {25'd0, b_v, b_op, b_src, b_a2r, b_rw, b_mr, b_mw},
                    {25'd0, e.v, e.op, e.src, e.a2r, e.rw, e.mr, e.mw});
      chk("b_rd",  {29'd0, b_rd}, {29'd0, e.rd});
      chk("b_rs1", b_r1, e.r1);
      chk("b_rs2", b_r2, e.r2);
      chk("b_imm", b_imm, e.imm);
      chk("b_stall_count", {30'd0, b_sc}, (e.sc > 3) ? 32'd3 : 32'(e.sc));
    end
  end

  // in_ready monitor: mid-cycle, after stimulus has settled.
  always @(negedge clk) begin
    logic r;
    #2;
    if (rdy_q.size() > 0) begin
      r = rdy_q.pop_front();
      chk("a_in_ready", {31'd0, a_rdy}, {31'd0, r});
      chk("b_in_ready", {31'd0, b_rdy}, {31'd0, r});
    end
  end

  function automatic logic [15:0] i_r(input logic [2:0] rd, input logic [2:0] s2, input logic [1:0] fn);
    return {3'b001, rd, s2, 5'b00000, fn};
  endfunction
  function automatic logic [15:0] i_op(input logic [2:0] opc, input logic [2:0] rd, input logic [9:0] imm);
    return {opc, rd, imm};
  endfunction

  function automatic exp_t mk(input logic v, input logic [1:0] op, input logic src, input logic a2r,
                              input logic rw, input logic mr, input logic mw, input logic [2:0] rd,
                              input logic [31:0] r1, input logic [31:0] r2, input logic [31:0] imm);
    exp_t e;
    e.v = v; e.op = op; e.src = src; e.a2r = a2r; e.rw = rw; e.mr = mr; e.mw = mw;
    e.rd = rd; e.r1 = r1; e.r2 = r2; e.imm = imm; e.sc = hz;
    return e;
  endfunction

  function automatic exp_t bub();
    return mk(0, 2'b00, 0, 0, 0, 0, 0, 3'd0, 32'd0, 32'd0, 32'd0);
  endfunction

  task automatic step(input logic iv, input logic [15:0] ins, input logic fl, input logic st,
                      input logic wr, input logic [2:0] wa, input logic [31:0] wd,
                      input logic rdy, input exp_t e);
    @(negedge clk);
    in_valid = iv; instruction = ins; flush = fl; ex_stall = st;
    wb_reg_write = wr; wb_addr = wa; wb_data = wd;
    rdy_q.push_back(rdy);
    exp_q.push_back(e);
  endtask

  exp_t held;

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // Reset state, then preload R1=5, R2=3 through write-back.
    step(0, 16'h0, 0, 0, 0, 3'd0, 32'd0, 1, bub());
    step(0, 16'h0, 0, 0, 1, 3'd1, 32'd5, 1, bub());
    step(0, 16'h0, 0, 0, 1, 3'd2, 32'd3, 1, bub());
    // ALU-R R1 op R2, funct 00; imm field = 0x100
    step(1, i_r(3'd1, 3'd2, 2'b00), 0, 0, 0, 3'd0, 32'd0, 1,
         mk(1, 2'b00, 0, 1, 1, 0, 0, 3'd1, 32'd5, 32'd3, 32'h100));
    // Bypass: write R4=0xAA while decoding ALU-I rd4 imm 0x3FF (rs2 field = R7)
    step(1, i_op(3'b010, 3'd4, 10'h3FF), 0, 0, 1, 3'd4, 32'hAA, 1,
         mk(1, 2'b00, 1, 1, 1, 0, 0, 3'd4, 32'hAA, 32'd0, 32'hFFFF_FFFF));
    // LOAD rd3 imm 0x010
    step(1, i_op(3'b011, 3'd3, 10'h010), 0, 0, 0, 3'd0, 32'd0, 1,
         mk(1, 2'b00, 1, 0, 1, 1, 0, 3'd3, 32'd0, 32'd0, 32'h10));
    // ALU-R with rs2=3: load-use bubble
    hz = 1;
    step(1, i_r(3'd1, 3'd3, 2'b01), 0, 0, 0, 3'd0, 32'd0, 0, bub());
    // Same instruction accepted next cycle; imm field = 0x181
    step(1, i_r(3'd1, 3'd3, 2'b01), 0, 0, 0, 3'd0, 32'd0, 1,
         mk(1, 2'b01, 0, 1, 1, 0, 0, 3'd1, 32'd5, 32'd0, 32'h181));
    // LOAD rd3 then LOAD rd5 whose rs2 field is 3: no stall
    step(1, i_op(3'b011, 3'd3, 10'h000), 0, 0, 0, 3'd0, 32'd0, 1,
         mk(1, 2'b00, 1, 0, 1, 1, 0, 3'd3, 32'd0, 32'd0, 32'd0));
    held = mk(1, 2'b00, 1, 0, 1, 1, 0, 3'd5, 32'd0, 32'd0, 32'h180);
    step(1, i_op(3'b011, 3'd5, 10'h180), 0, 0, 0, 3'd0, 32'd0, 1, held);
    // ex_stall for 3 cycles with a dependent instruction waiting: hold, no hazard counted
    for (int k = 0; k < 3; k++)
      step(1, i_op(3'b010, 3'd5, 10'h001), 0, 1, 0, 3'd0, 32'd0, 0, held);
    // flush during ex_stall
    step(1, i_op(3'b010, 3'd5, 10'h001), 1, 1, 0, 3'd0, 32'd0, 1, bub());
    // STORE rs1=R2 imm 0x055
    step(1, i_op(3'b100, 3'd2, 10'h055), 0, 0, 0, 3'd0, 32'd0, 1,
         mk(1, 2'b00, 1, 0, 0, 0, 1, 3'd2, 32'd3, 32'd0, 32'h55));
    // Opcode 111: valid, no controls; rs2 field = R2
    step(1, i_op(3'b111, 3'd1, 10'h100), 0, 0, 0, 3'd0, 32'd0, 1,
         mk(1, 2'b00, 0, 0, 0, 0, 0, 3'd1, 32'd5, 32'd3, 32'h100));
    // imm 0x200 sign-extends; rs2 field = R4 (0xAA)
    step(1, i_op(3'b010, 3'd6, 10'h200), 0, 0, 0, 3'd0, 32'd0, 1,
         mk(1, 2'b00, 1, 1, 1, 0, 0, 3'd6, 32'd0, 32'hAA, 32'hFFFF_FE00));
    // Four more load-use hazards: 16-bit counter reaches 5, 2-bit saturates at 3
    for (int k = 0; k < 4; k++) begin
      step(1, i_op(3'b011, 3'd7, 10'h000), 0, 0, 0, 3'd0, 32'd0, 1,
           mk(1, 2'b00, 1, 0, 1, 1, 0, 3'd7, 32'd0, 32'd0, 32'd0));
      hz++;
      step(1, i_op(3'b010, 3'd7, 10'h001), 0, 0, 0, 3'd0, 32'd0, 0, bub());
      step(1, i_op(3'b010, 3'd7, 10'h001), 0, 0, 0, 3'd0, 32'd0, 1,
           mk(1, 2'b00, 1, 1, 1, 0, 0, 3'd7, 32'd0, 32'd0, 32'd1));
    end

    // Asynchronous reset mid-stream with ex_valid=1
    @(negedge clk);
    in_valid = 1'b0;
    hz = 0;
    exp_q.push_back(bub());
    #2 rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    // Register file cleared: ALU-R R1,R2 reads zeros
    step(1, i_r(3'd1, 3'd2, 2'b00), 0, 0, 0, 3'd0, 32'd0, 1,
         mk(1, 2'b00, 0, 1, 1, 0, 0, 3'd1, 32'd0, 32'd0, 32'h100));
    step(0, 16'h0, 0, 0, 0, 3'd0, 32'd0, 1, bub());

    repeat (3) @(negedge clk);
    total++;
    if (exp_q.size() != 0 || rdy_q.size() != 0) begin
      bad++;
      $display("FAIL drain got=%0d want=0", exp_q.size() + rdy_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
